// File: rtl/fwd_sel_unit_if.sv
// Operand-forwarding handshake between decode and the forwarding-select unit.
// Decode (master) presents the ID instruction. The unit (slave) returns the
// registered EX operand selects and the combinational load-use stall request.
interface fwd_sel_unit_if #(
  parameter int RA_W = 4
);
  logic            id_valid;
  logic [RA_W-1:0] id_rs_a;
  logic [RA_W-1:0] id_rs_b;
  logic            id_wr_en;
  logic [RA_W-1:0] id_rd;
  logic            id_wr32;
  logic            id_is_load;
  logic            flush;
  logic [2:0]      ex_src_a;
  logic [2:0]      ex_src_b;
  logic            stall_req;

  modport master (
    output id_valid, id_rs_a, id_rs_b, id_wr_en, id_rd, id_wr32, id_is_load, flush,
    input  ex_src_a, ex_src_b, stall_req
  );

  modport slave (
    input  id_valid, id_rs_a, id_rs_b, id_wr_en, id_rd, id_wr32, id_is_load, flush,
    output ex_src_a, ex_src_b, stall_req
  );
endinterface

// File: rtl/fwd_sel_unit.sv
// Forwarding-select generator for the EX-stage operand muxes.
// The unit tracks the destinations of the instructions in EX and MEM. It
// resolves each ID source register against them and registers a 3-bit select:
//   000 regfile, 001 MEM hi, 010 MEM lo, 011 WB hi, 100 WB lo.
// A consumer of a load still in EX or MEM raises a combinational stall request.
module fwd_sel_unit #(
  parameter int RA_W = 4
) (
  input logic          clk,
  input logic          rst_n,
  fwd_sel_unit_if.slave bus
);

  typedef struct packed {
    logic            valid;
    logic            wr_en;
    logic [RA_W-1:0] rd;
    logic            wr32;
    logic            is_load;
  } slot_t;

  localparam logic [2:0] SEL_REG    = 3'b000;
  localparam logic [2:0] SEL_MEM_HI = 3'b001;
  localparam logic [2:0] SEL_MEM_LO = 3'b010;
  localparam logic [2:0] SEL_WB_HI  = 3'b011;
  localparam logic [2:0] SEL_WB_LO  = 3'b100;

  slot_t      ex_slot_q,  ex_slot_d;
  slot_t      mem_slot_q, mem_slot_d;
  logic [2:0] ex_src_a_q, ex_src_a_d;
  logic [2:0] ex_src_b_q, ex_src_b_d;
  logic       stall_c;
  logic       advance_id;

  // Returns {hi, lo}. A 32-bit result occupies rd (hi) and rd+1 (lo, wrapping).
  // R0 always reads zero, so it is never forwarded.
  function automatic logic [1:0] slot_match(input logic [RA_W-1:0] s, input slot_t slot);
    logic [RA_W-1:0] rd_next;
    logic            hi;
    logic            lo;
    rd_next = slot.rd + RA_W'(1);
    hi      = 1'b0;
    lo      = 1'b0;
    if (slot.valid && slot.wr_en && (s != '0)) begin
      if (slot.wr32) begin
        hi = (s == slot.rd);
        lo = (s == rd_next);
      end else begin
        lo = (s == slot.rd);
      end
    end
    return {hi, lo};
  endfunction

  // The EX slot holds the newest writer, so it is checked before the MEM slot.
  function automatic logic [2:0] select_for(input logic [RA_W-1:0] s,
                                            input slot_t ex_s, input slot_t mem_s);
    logic [1:0] em;
    logic [1:0] mm;
    em = slot_match(s, ex_s);
    mm = slot_match(s, mem_s);
    if (em[1])      return SEL_MEM_HI;
    else if (em[0]) return SEL_MEM_LO;
    else if (mm[1]) return SEL_WB_HI;
    else if (mm[0]) return SEL_WB_LO;
    else            return SEL_REG;
  endfunction

  function automatic logic load_hit(input logic [RA_W-1:0] s, input slot_t slot);
    return slot.is_load && (slot_match(s, slot) != 2'b00);
  endfunction

  // Load-use detection. The regfile writes through, so only EX and MEM loads matter.
  always_comb begin
    stall_c = bus.id_valid &&
              (load_hit(bus.id_rs_a, ex_slot_q) || load_hit(bus.id_rs_a, mem_slot_q) ||
               load_hit(bus.id_rs_b, ex_slot_q) || load_hit(bus.id_rs_b, mem_slot_q));
  end

  // Next-state logic: shift the slots, and bubble EX on stall, flush or an empty ID.
  always_comb begin
    advance_id = bus.id_valid && !stall_c && !bus.flush;
    ex_slot_d  = '0;
    mem_slot_d = ex_slot_q;
    ex_src_a_d = SEL_REG;
    ex_src_b_d = SEL_REG;
    if (advance_id) begin
      ex_slot_d.valid   = 1'b1;
      ex_slot_d.wr_en   = bus.id_wr_en;
      ex_slot_d.rd      = bus.id_rd;
      ex_slot_d.wr32    = bus.id_wr32;
      ex_slot_d.is_load = bus.id_is_load;
      ex_src_a_d        = select_for(bus.id_rs_a, ex_slot_q, mem_slot_q);
      ex_src_b_d        = select_for(bus.id_rs_b, ex_slot_q, mem_slot_q);
    end
  end

  // Pipeline tracking slots and registered operand selects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_slot_q  <= '0;
      mem_slot_q <= '0;
      ex_src_a_q <= SEL_REG;
      ex_src_b_q <= SEL_REG;
    end else begin
      ex_slot_q  <= ex_slot_d;
      mem_slot_q <= mem_slot_d;
      ex_src_a_q <= ex_src_a_d;
      ex_src_b_q <= ex_src_b_d;
    end
  end

  assign bus.ex_src_a  = ex_src_a_q;
  assign bus.ex_src_b  = ex_src_b_q;
  assign bus.stall_req = stall_c;

endmodule

// File: tb/tb_fwd_sel_unit.sv
// Directed table-driven bench for fwd_sel_unit.
// Each row is one ID-stage cycle. The row gives the stall expected before
// the clock edge and the selects expected after the edge.
module tb_fwd_sel_unit;

  typedef struct {
    string      name;
    logic       valid;
    logic [3:0] rs_a;
    logic [3:0] rs_b;
    logic       wr_en;
    logic [3:0] rd;
    logic       wr32;
    logic       ld;
    logic       flush;
    logic       exp_stall;
    logic [2:0] exp_a;
    logic [2:0] exp_b;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  vec_t vecs[$];

  fwd_sel_unit_if #(.RA_W(4)) bus ();

  fwd_sel_unit #(.RA_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string name, input logic [2:0] got, input logic [2:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got %b want %b", name, got, want);
    end
  endtask

  task automatic add_vec(input string n, input int v, input int a, input int b, input int w,
                         input int d, input int w32, input int ld, input int fl,
                         input int es, input int ea, input int eb);
    vec_t x;
    x.name = n;  x.valid = 1'(v); x.rs_a = 4'(a); x.rs_b = 4'(b);
    x.wr_en = 1'(w); x.rd = 4'(d); x.wr32 = 1'(w32); x.ld = 1'(ld); x.flush = 1'(fl);
    x.exp_stall = 1'(es); x.exp_a = 3'(ea); x.exp_b = 3'(eb);
    vecs.push_back(x);
  endtask

  task automatic drive(input vec_t x);
    bus.id_valid   = x.valid;
    bus.id_rs_a    = x.rs_a;
    bus.id_rs_b    = x.rs_b;
    bus.id_wr_en   = x.wr_en;
    bus.id_rd      = x.rd;
    bus.id_wr32    = x.wr32;
    bus.id_is_load = x.ld;
    bus.flush      = x.flush;
  endtask

  task automatic apply_stimulus(input vec_t x);
    @(negedge clk);
    drive(x);
    #1;
    check_output({x.name, ".stall"}, {2'b00, bus.stall_req}, {2'b00, x.exp_stall});
    @(posedge clk);
    #1;
    check_output({x.name, ".src_a"}, bus.ex_src_a, x.exp_a);
    check_output({x.name, ".src_b"}, bus.ex_src_b, x.exp_b);
  endtask

  initial begin
    vec_t idle;
    checks = 0;
    errors = 0;
    idle = '{name:"idle", valid:1'b0, rs_a:4'd0, rs_b:4'd0, wr_en:1'b0, rd:4'd0,
             wr32:1'b0, ld:1'b0, flush:1'b0, exp_stall:1'b0, exp_a:3'd0, exp_b:3'd0};

    //        name         v  a   b  w  rd w32 ld fl  st  a  b
    add_vec("add_r3",      1, 1,  2, 1, 3, 0, 0, 0,  0, 0, 0);
    add_vec("sub_b2b",     1, 3,  0, 1, 7, 0, 0, 0,  0, 2, 0);
    add_vec("nop_a",       0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0);
    add_vec("nop_b",       0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0);
    add_vec("add_r3_2",    1, 1,  2, 1, 3, 0, 0, 0,  0, 0, 0);
    add_vec("nop_c",       0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0);
    add_vec("use_1nop",    1, 3,  1, 1, 8, 0, 0, 0,  0, 4, 0);
    add_vec("add_r3_3",    1, 0,  0, 1, 3, 0, 0, 0,  0, 0, 0);
    add_vec("nop_d",       0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0);
    add_vec("nop_e",       0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0);
    add_vec("use_2nop",    1, 3,  8, 0, 0, 0, 0, 0,  0, 0, 0);
    add_vec("mul_r4",      1, 1,  2, 1, 4, 1, 0, 0,  0, 0, 0);
    add_vec("use_r4_r5",   1, 4,  5, 0, 0, 0, 0, 0,  0, 1, 2);
    add_vec("use_r5_r4wb", 1, 5,  4, 0, 0, 0, 0, 0,  0, 4, 3);
    add_vec("mul_r15",     1, 1,  2, 1, 15,1, 0, 0,  0, 0, 0);
    add_vec("use_r0_r15",  1, 0, 15, 0, 0, 0, 0, 0,  0, 0, 1);
    add_vec("use_r0_r15wb",1, 0, 15, 0, 0, 0, 0, 0,  0, 0, 3);
    add_vec("add_r2_old",  1, 1,  1, 1, 2, 0, 0, 0,  0, 0, 0);
    add_vec("add_r2_new",  1, 5,  6, 1, 2, 0, 0, 0,  0, 0, 0);
    add_vec("use_r2",      1, 2,  2, 0, 0, 0, 0, 0,  0, 2, 2);
    add_vec("nop_f",       0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0);
    add_vec("ld_r6",       1, 1,  0, 1, 6, 0, 1, 0,  0, 0, 0);
    add_vec("use_r6_st1",  1, 6,  0, 1, 9, 0, 0, 0,  1, 0, 0);
    add_vec("use_r6_st2",  1, 6,  0, 1, 9, 0, 0, 0,  1, 0, 0);
    add_vec("use_r6_go",   1, 6,  0, 1, 9, 0, 0, 0,  0, 0, 0);
    add_vec("ld_r6_b",     1, 0,  0, 1, 6, 0, 1, 0,  0, 0, 0);
    add_vec("nop_g",       0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0);
    add_vec("use_r6b_st",  1, 1,  6, 0, 0, 0, 0, 0,  1, 0, 0);
    add_vec("use_r6b_go",  1, 1,  6, 0, 0, 0, 0, 0,  0, 0, 0);
    add_vec("add_r5",      1, 1,  2, 1, 5, 0, 0, 0,  0, 0, 0);
    add_vec("flush_dep",   1, 5,  0, 1, 10,0, 0, 1,  0, 0, 0);
    add_vec("use_r10_r5",  1, 10, 5, 0, 0, 0, 0, 0,  0, 0, 4);
    add_vec("ld_r7",       1, 0,  0, 1, 7, 0, 1, 0,  0, 0, 0);
    add_vec("flush_stall", 1, 7,  0, 0, 0, 0, 0, 1,  1, 0, 0);
    add_vec("use_r7_st",   1, 7,  0, 0, 0, 0, 0, 0,  1, 0, 0);
    add_vec("use_r7_go",   1, 7,  0, 0, 0, 0, 0, 0,  0, 0, 0);
    add_vec("rs_add_r3",   1, 1,  2, 1, 3, 0, 0, 0,  0, 0, 0);
    add_vec("rs_ld_r6",    1, 3,  0, 1, 6, 0, 1, 0,  0, 2, 0);

    // Power-on reset: outputs must be cleared while reset is held.
    rst_n = 1'b0;
    drive(idle);
    #1;
    check_output("por.src_a", bus.ex_src_a, 3'b000);
    check_output("por.src_b", bus.ex_src_b, 3'b000);
    check_output("por.stall", {2'b00, bus.stall_req}, 3'b000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply_stimulus(vecs[i]);

    // Reset asserted mid-stall: the stall and the selects drop at once, and nothing is replayed.
    @(negedge clk);
    bus.id_valid = 1'b1; bus.id_rs_a = 4'd6; bus.id_rs_b = 4'd0;
    bus.id_wr_en = 1'b0; bus.id_is_load = 1'b0; bus.flush = 1'b0;
    #1;
    check_output("rst_pre.stall", {2'b00, bus.stall_req}, 3'b001);
    rst_n = 1'b0;
    #1;
    check_output("rst_mid.stall", {2'b00, bus.stall_req}, 3'b000);
    check_output("rst_mid.src_a", bus.ex_src_a, 3'b000);
    check_output("rst_mid.src_b", bus.ex_src_b, 3'b000);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_output("rst_post.stall", {2'b00, bus.stall_req}, 3'b000);
    @(posedge clk);
    #1;
    check_output("rst_post.src_a", bus.ex_src_a, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
